// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the clock set-mode controller
package clock_pkg;

    // State codes double as the edit_field codes shown to the display logic.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EDIT_H = 2'b01,
        ST_EDIT_M = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    localparam logic [1:0] FIELD_NONE    = 2'b00;
    localparam logic [1:0] FIELD_HOURS   = 2'b01;
    localparam logic [1:0] FIELD_MINUTES = 2'b10;
    localparam logic [1:0] FIELD_COMMIT  = 2'b11;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic logic [1:0] field_of(input state_t st);
        case (st)
            ST_EDIT_H: field_of = FIELD_HOURS;
            ST_EDIT_M: field_of = FIELD_MINUTES;
            ST_COMMIT: field_of = FIELD_COMMIT;
            default:   field_of = FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// rtl/bin2bcd_60.sv - combinational binary (0..59) to two-digit BCD converter
//
// Ports:
//   bin_in  in  6       binary value, 0..59
//   tens    out TENS_W  tens digit (narrow it to 2 bits for hours)
//   units   out 4       units digit
module bin2bcd_60 #(
    parameter int TENS_W = 4
) (
    input  logic [5:0]        bin_in,
    output logic [TENS_W-1:0] tens,
    output logic [3:0]        units
);

    always_comb begin
        tens  = '0;
        units = 4'(bin_in);
        if (bin_in >= 6'd50) begin
            tens  = TENS_W'(5);
            units = 4'(bin_in - 6'd50);
        end else if (bin_in >= 6'd40) begin
            tens  = TENS_W'(4);
            units = 4'(bin_in - 6'd40);
        end else if (bin_in >= 6'd30) begin
            tens  = TENS_W'(3);
            units = 4'(bin_in - 6'd30);
        end else if (bin_in >= 6'd20) begin
            tens  = TENS_W'(2);
            units = 4'(bin_in - 6'd20);
        end else if (bin_in >= 6'd10) begin
            tens  = TENS_W'(1);
            units = 4'(bin_in - 6'd10);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - button-driven set-mode controller for the alarm-clock core
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   btn_time/alarm/up/next/cancel one-cycle debounced button pulses
//   cur_h1/h0/m1/m0              current time digits (BCD) from the core
//   H_in1/H_in0/M_in1/M_in0      edited digits (BCD) to the core, registered
//   LD_time/LD_alarm             load strobes, held LOAD_HOLD cycles in COMMIT
//   edit_field                   00 none, 01 hours, 10 minutes, 11 committing
//   edit_alarm                   current edit targets the alarm
//   blink                        blink for the selected field
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int LOAD_HOLD   = 24,
    parameter int TIMEOUT_CYC = 4096,
    parameter int BLINK_HALF  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_up,
    input  logic       btn_next,
    input  logic       btn_cancel,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] edit_field,
    output logic       edit_alarm,
    output logic       blink
);

    localparam int HOLD_W  = $clog2(LOAD_HOLD + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    state_t             state_q, state_d;
    logic [4:0]         edit_hr_q, edit_hr_d;
    logic [5:0]         edit_min_q, edit_min_d;
    logic               edit_alarm_q, edit_alarm_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               ld_time_q, ld_time_d;
    logic               ld_alarm_q, ld_alarm_d;
    logic [1:0]         h_in1_q, h_in1_d;
    logic [3:0]         h_in0_q, h_in0_d;
    logic [3:0]         m_in1_q, m_in1_d;
    logic [3:0]         m_in0_q, m_in0_d;

    logic any_btn, timeout, up_act, entered, edit_next;

    // Digits are converted from the next-cycle values so they land together
    // with the state change, one cycle after the button.
    bin2bcd_60 #(.TENS_W(2)) u_hr_bcd (
        .bin_in ({1'b0, edit_hr_d}),
        .tens   (h_in1_d),
        .units  (h_in0_d)
    );

    bin2bcd_60 #(.TENS_W(4)) u_min_bcd (
        .bin_in (edit_min_d),
        .tens   (m_in1_d),
        .units  (m_in0_d)
    );

    always_comb begin
        state_d      = state_q;
        edit_hr_d    = edit_hr_q;
        edit_min_d   = edit_min_q;
        edit_alarm_d = edit_alarm_q;
        hold_cnt_d   = '0;
        tmo_cnt_d    = '0;
        blink_cnt_d  = '0;
        blink_d      = 1'b0;
        up_act       = 1'b0;

        any_btn = btn_time | btn_alarm | btn_up | btn_next | btn_cancel;
        timeout = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

        case (state_q)
            ST_IDLE: begin
                if (btn_time || btn_alarm) begin
                    state_d      = ST_EDIT_H;
                    edit_alarm_d = ~btn_time;
                    edit_hr_d    = 5'(cur_h1) * 5'd10 + 5'(cur_h0);
                    edit_min_d   = 6'(cur_m1) * 6'd10 + 6'(cur_m0);
                end
            end
            ST_EDIT_H: begin
                if (btn_cancel || timeout) begin
                    state_d = ST_IDLE;
                end else if (btn_next) begin
                    state_d = ST_EDIT_M;
                end else if (btn_up) begin
                    up_act    = 1'b1;
                    edit_hr_d = (edit_hr_q == HR_MAX) ? 5'd0 : edit_hr_q + 5'd1;
                end
            end
            ST_EDIT_M: begin
                if (btn_cancel || timeout) begin
                    state_d = ST_IDLE;
                end else if (btn_next) begin
                    state_d = ST_COMMIT;
                end else if (btn_up) begin
                    up_act     = 1'b1;
                    edit_min_d = (edit_min_q == MIN_MAX) ? 6'd0 : edit_min_q + 6'd1;
                end
            end
            ST_COMMIT: begin
                if (hold_cnt_q == HOLD_W'(LOAD_HOLD - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            edit_alarm_d = 1'b0;
        end

        entered   = (state_d != state_q);
        edit_next = (state_d == ST_EDIT_H) || (state_d == ST_EDIT_M);

        if (edit_next && !entered && !any_btn) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        // Blink restarts high on entry and on an accepted increment.
        if (edit_next) begin
            if (entered || up_act) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        ld_time_d  = (state_d == ST_COMMIT) && !edit_alarm_d;
        ld_alarm_d = (state_d == ST_COMMIT) &&  edit_alarm_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            edit_hr_q    <= '0;
            edit_min_q   <= '0;
            edit_alarm_q <= 1'b0;
            hold_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            ld_time_q    <= 1'b0;
            ld_alarm_q   <= 1'b0;
            h_in1_q      <= '0;
            h_in0_q      <= '0;
            m_in1_q      <= '0;
            m_in0_q      <= '0;
        end else begin
            state_q      <= state_d;
            edit_hr_q    <= edit_hr_d;
            edit_min_q   <= edit_min_d;
            edit_alarm_q <= edit_alarm_d;
            hold_cnt_q   <= hold_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            ld_time_q    <= ld_time_d;
            ld_alarm_q   <= ld_alarm_d;
            h_in1_q      <= h_in1_d;
            h_in0_q      <= h_in0_d;
            m_in1_q      <= m_in1_d;
            m_in0_q      <= m_in0_d;
        end
    end

    assign H_in1      = h_in1_q;
    assign H_in0      = h_in0_q;
    assign M_in1      = m_in1_q;
    assign M_in0      = m_in0_q;
    assign LD_time    = ld_time_q;
    assign LD_alarm   = ld_alarm_q;
    assign edit_field = field_of(state_q);
    assign edit_alarm = edit_alarm_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

    localparam int LOAD_HOLD   = 24;
    localparam int TIMEOUT_CYC = 4096;
    localparam int BLINK_HALF  = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_time, btn_alarm, btn_up, btn_next, btn_cancel;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0, cur_m1, cur_m0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm;
    logic [1:0] edit_field;
    logic       edit_alarm, blink;

    int n_tests = 0;
    int n_fail  = 0;

    clock_set_ctrl #(
        .LOAD_HOLD   (LOAD_HOLD),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_time   (btn_time),
        .btn_alarm  (btn_alarm),
        .btn_up     (btn_up),
        .btn_next   (btn_next),
        .btn_cancel (btn_cancel),
        .cur_h1     (cur_h1),
        .cur_h0     (cur_h0),
        .cur_m1     (cur_m1),
        .cur_m0     (cur_m0),
        .H_in1      (H_in1),
        .H_in0      (H_in0),
        .M_in1      (M_in1),
        .M_in0      (M_in0),
        .LD_time    (LD_time),
        .LD_alarm   (LD_alarm),
        .edit_field (edit_field),
        .edit_alarm (edit_alarm),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 hours, 2 minutes, 3 committing.
    int m_mode  = 0;
    int m_hr    = 0;
    int m_min   = 0;
    int m_alarm = 0;
    int m_idle  = 0;
    int m_hold  = 0;
    int m_age   = 0;

    always @(posedge clk or negedge reset_n) begin
        int  prev;
        bit  any, up_acts;
        if (!reset_n) begin
            m_mode = 0; m_hr = 0; m_min = 0; m_alarm = 0;
            m_idle = 0; m_hold = 0; m_age = 0;
        end else begin
            prev    = m_mode;
            any     = btn_time | btn_alarm | btn_up | btn_next | btn_cancel;
            up_acts = 0;
            case (m_mode)
                0: if (btn_time || btn_alarm) begin
                    m_mode  = 1;
                    m_alarm = btn_time ? 0 : 1;
                    m_hr    = cur_h1 * 10 + cur_h0;
                    m_min   = cur_m1 * 10 + cur_m0;
                end
                1: if (btn_cancel || m_idle == TIMEOUT_CYC - 1) m_mode = 0;
                   else if (btn_next) m_mode = 2;
                   else if (btn_up) begin m_hr = (m_hr + 1) % 24; up_acts = 1; end
                2: if (btn_cancel || m_idle == TIMEOUT_CYC - 1) m_mode = 0;
                   else if (btn_next) m_mode = 3;
                   else if (btn_up) begin m_min = (m_min + 1) % 60; up_acts = 1; end
                default: begin
                    m_hold++;
                    if (m_hold == LOAD_HOLD) m_mode = 0;
                end
            endcase
            if (m_mode != prev) begin
                m_idle = 0; m_hold = 0; m_age = 0;
            end else begin
                m_idle = any ? 0 : m_idle + 1;
                m_age  = up_acts ? 0 : m_age + 1;
            end
            if (m_mode == 0) m_alarm = 0;
        end
        #1;
        check("H_in1",      H_in1,      m_hr / 10);
        check("H_in0",      H_in0,      m_hr % 10);
        check("M_in1",      M_in1,      m_min / 10);
        check("M_in0",      M_in0,      m_min % 10);
        check("edit_field", edit_field, m_mode);
        check("edit_alarm", edit_alarm, m_alarm);
        check("LD_time",    LD_time,    (m_mode == 3 && m_alarm == 0) ? 1 : 0);
        check("LD_alarm",   LD_alarm,   (m_mode == 3 && m_alarm == 1) ? 1 : 0);
        check("blink",      blink,
              ((m_mode == 1 || m_mode == 2) && ((m_age / BLINK_HALF) % 2 == 0)) ? 1 : 0);
    end

    task automatic set_cur(input int h, input int m);
        cur_h1 = 2'(h / 10);
        cur_h0 = 4'(h % 10);
        cur_m1 = 4'(m / 10);
        cur_m0 = 4'(m % 10);
    endtask

    task automatic press(input bit t, input bit a, input bit u, input bit n, input bit c);
        btn_time = t; btn_alarm = a; btn_up = u; btn_next = n; btn_cancel = c;
        @(negedge clk);
        btn_time = 0; btn_alarm = 0; btn_up = 0; btn_next = 0; btn_cancel = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_digits(input string name, input int h, input int m);
        check({name, "_h1"}, H_in1, h / 10);
        check({name, "_h0"}, H_in0, h % 10);
        check({name, "_m1"}, M_in1, m / 10);
        check({name, "_m0"}, M_in0, m % 10);
    endtask

    // Counts strobe cycles while committing, optionally hammering buttons.
    task automatic count_commit(input bit alarm, input bit noisy, output int cnt);
        int guard;
        cnt   = 0;
        guard = 0;
        while (edit_field == 2'b11 && guard < 100) begin
            if (alarm ? LD_alarm : LD_time) cnt++;
            if (noisy) begin
                btn_time = 1'($urandom); btn_alarm = 1'($urandom); btn_up = 1'($urandom);
                btn_next = 1'($urandom); btn_cancel = 1'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        btn_time = 0; btn_alarm = 0; btn_up = 0; btn_next = 0; btn_cancel = 0;
        check("commit_bounded", (guard < 100) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ld_seen;
        reset_n = 1'b1;
        btn_time = 0; btn_alarm = 0; btn_up = 0; btn_next = 0; btn_cancel = 0;
        set_cur(0, 0);
        #2 reset_n = 1'b0;
        idle(2);
        check("rst_field", edit_field, 0);
        check("rst_ld", {LD_time, LD_alarm, blink, edit_alarm}, 0);
        check_digits("rst", 0, 0);
        reset_n = 1'b1;
        idle(1);

        // Time edit from 12:34 with both wraps, then commit.
        set_cur(12, 34);
        press(1, 0, 0, 0, 0);
        check("t1_field", edit_field, 1);
        check_digits("t1_seed", 12, 34);
        check("t1_ld", LD_time, 0);
        repeat (12) press(0, 0, 1, 0, 0);
        check_digits("t1_hwrap", 0, 34);
        press(0, 0, 0, 1, 0);
        repeat (26) press(0, 0, 1, 0, 0);
        check_digits("t1_mwrap", 0, 0);
        press(0, 0, 0, 1, 0);
        count_commit(0, 0, cnt);
        check("t1_hold", cnt, LOAD_HOLD);
        check("t1_back_idle", edit_field, 0);

        // Alarm edit from 06:05.
        set_cur(6, 5);
        press(0, 1, 0, 0, 0);
        check("t2_alarm", edit_alarm, 1);
        press(0, 0, 0, 1, 0);
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 1, 0);
        check_digits("t2_commit", 6, 6);
        check("t2_ld_time", LD_time, 0);
        count_commit(1, 0, cnt);
        check("t2_hold", cnt, LOAD_HOLD);
        check("t2_alarm_clr", edit_alarm, 0);

        // Cancel wins over next and up.
        set_cur(12, 34);
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        press(0, 0, 1, 0, 0);
        press(0, 0, 1, 1, 1);
        check("t3_field", edit_field, 0);
        check_digits("t3_keep", 12, 35);
        ld_seen = 0;
        repeat (30) begin
            ld_seen = ld_seen | LD_time | LD_alarm;
            @(negedge clk);
        end
        check("t3_no_load", ld_seen, 0);

        // Timeout: still editing at TIMEOUT_CYC-1 cycles, idle one cycle later.
        press(1, 0, 0, 0, 0);
        idle(TIMEOUT_CYC - 1);
        check("t4_before", edit_field, 1);
        idle(1);
        check("t4_after", edit_field, 0);
        check("t4_no_load", {LD_time, LD_alarm}, 0);

        // Reset during commit hold cycle 5.
        set_cur(9, 41);
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 1, 0);
        idle(4);
        check("t5_ld_pre", LD_time, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_ld_rst", LD_time, 0);
        check("t5_field_rst", edit_field, 0);
        check_digits("t5_rst", 0, 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        press(0, 0, 1, 0, 0);
        press(0, 0, 0, 1, 0);
        check("t5_up_ignored", edit_field, 0);
        check_digits("t5_after", 0, 0);

        // Simultaneous time+alarm, then buttons hammered during commit.
        set_cur(23, 59);
        press(1, 1, 0, 0, 0);
        check("t6_alarm", edit_alarm, 0);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 1, 0);
        count_commit(0, 1, cnt);
        check("t6_hold", cnt, LOAD_HOLD);
        idle(1);

        // Random traffic against the model.
        repeat (3000) begin
            set_cur($urandom_range(0, 23), $urandom_range(0, 59));
            btn_time   = ($urandom_range(0, 19) == 0);
            btn_alarm  = ($urandom_range(0, 19) == 0);
            btn_up     = ($urandom_range(0, 2) == 0);
            btn_next   = ($urandom_range(0, 9) == 0);
            btn_cancel = ($urandom_range(0, 39) == 0);
            @(negedge clk);
        end
        btn_time = 0; btn_alarm = 0; btn_up = 0; btn_next = 0; btn_cancel = 0;
        idle(LOAD_HOLD + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Button-driven set-mode controller that sequences the alarm-clock core's load interface.
- Lets the user edit hours and minutes for either the time-of-day or the alarm, then commits them.
- A commit drives the core's H_in1/H_in0/M_in1/M_in0 digits and holds LD_time or LD_alarm long enough for the core's slow 1 s tick to sample them.
- Sits between the debounced front-panel buttons and the clock core.

Parameters:
- LOAD_HOLD, 24: clk cycles the load strobe and digits are held in COMMIT. Must be at least two core 1 s tick periods.
- TIMEOUT_CYC, 4096: idle clk cycles in an edit state before the edit is silently aborted.
- BLINK_HALF, 8: clk cycles per half-period of the blink output.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_time  in  1  one-cycle pulse: start editing time-of-day
- btn_alarm  in  1  one-cycle pulse: start editing alarm
- btn_up  in  1  one-cycle pulse: increment the selected field
- btn_next  in  1  one-cycle pulse: advance field (hours -> minutes -> commit)
- btn_cancel  in  1  one-cycle pulse: abort edit
- cur_h1  in  2  current-time hours tens digit (BCD) from the core
- cur_h0  in  4  current-time hours units digit (BCD) from the core
- cur_m1  in  4  current-time minutes tens digit (BCD) from the core
- cur_m0  in  4  current-time minutes units digit (BCD) from the core
- H_in1  out  2  hours tens digit to the core
- H_in0  out  4  hours units digit to the core
- M_in1  out  4  minutes tens digit to the core
- M_in0  out  4  minutes units digit to the core
- LD_time  out  1  load time-of-day, held for LOAD_HOLD cycles
- LD_alarm  out  1  load alarm, held for LOAD_HOLD cycles
- edit_field  out  2  00 none, 01 hours, 10 minutes, 11 committing
- edit_alarm  out  1  1 while the current edit targets the alarm
- blink  out  1  display blink for the selected field; 0 outside edit

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; edit_hr=0, edit_min=0; all outputs 0.
  - Digits therefore output 0,0,0,0.
  - Applies immediately, including mid-COMMIT: LD_* drop asynchronously and no partial load is retained.
- Storage: edit_hr is 5-bit binary, range 0..23; edit_min is 6-bit binary, range 0..59. Outputs are the BCD conversions of these, always driven, registered.
- FSM states: IDLE, EDIT_H, EDIT_M, COMMIT.
- IDLE:
  - btn_time enters EDIT_H with edit_alarm=0.
  - btn_alarm enters EDIT_H with edit_alarm=1.
  - If both pulse in the same cycle, btn_time wins.
  - On entry, seed edit_hr = cur_h1*10 + cur_h0 and edit_min = cur_m1*10 + cur_m0, sampled that cycle.
  - btn_up, btn_next and btn_cancel are ignored.
- EDIT_H:
  - btn_up: edit_hr+1, wrapping 23 -> 0.
  - btn_next: go to EDIT_M.
- EDIT_M:
  - btn_up: edit_min+1, wrapping 59 -> 0. No carry into hours.
  - btn_next: go to COMMIT.
- Priority in edit states: btn_cancel > btn_next > btn_up. Only the highest-priority button acts in a given cycle.
- btn_cancel in an edit state returns to IDLE with no load strobe. edit_hr and edit_min keep their values.
- Timeout:
  - A counter resets on any button pulse and on state entry.
  - Reaching TIMEOUT_CYC-1 in EDIT_H or EDIT_M acts as a cancel.
- COMMIT:
  - Asserts LD_alarm if edit_alarm=1, else LD_time, for exactly LOAD_HOLD consecutive cycles starting the cycle after entry.
  - Digits are frozen throughout.
  - All buttons are ignored, including cancel.
  - Then returns to IDLE; LD_* go low that same cycle.
  - LD_time and LD_alarm are never high together.
- edit_field: 01 in EDIT_H, 10 in EDIT_M, 11 in COMMIT, 00 in IDLE. edit_alarm is cleared on return to IDLE.
- blink:
  - Toggles every BLINK_HALF cycles in EDIT_H and EDIT_M.
  - Restarts high on each state entry and on each btn_up, so the incremented value is visible.
  - 0 in IDLE and COMMIT.
- Latency: a button pulse at cycle n updates the digits and edit_field at cycle n+1.

Decomposition:
- Shared package clock_pkg:
  - state encoding and edit_field codes
  - constants HR_MAX=23 and MIN_MAX=59
- One sub-module, bin2bcd_60: 6-bit binary in (0..59), tens/units BCD out, combinational.
  - Used twice: hours, with tens truncated to 2 bits, and minutes.
- Counters (hold, timeout, blink) stay inline.

Test Plan:
- Reset, then btn_time with cur=12:34 -> edit_field=01; digits 1,2,3,4 next cycle; LD_time=0.
- From 12:34, btn_up x12 in EDIT_H -> hours 00 (wrap at 23->0); btn_next, btn_up x26 -> minutes 00 (59->0, hours unchanged 00); btn_next -> LD_time high exactly LOAD_HOLD cycles, digits 0,0,0,0 stable, LD_alarm=0, then IDLE.
- btn_alarm with cur=06:05, btn_next, btn_up, btn_next -> LD_alarm held LOAD_HOLD cycles with digits 0,6,0,6; edit_alarm=1 until IDLE.
- In EDIT_M, btn_cancel+btn_next+btn_up same cycle -> IDLE, no LD_* pulse, minutes unchanged. Separately, no buttons for TIMEOUT_CYC cycles -> IDLE, no load.
- Deassert reset_n at COMMIT hold cycle 5 -> LD_time=0 immediately, digits 0; after release, state IDLE and btn_up has no effect.
- btn_time and btn_alarm in the same cycle -> edit_alarm=0. Buttons pulsed during COMMIT -> no effect on the hold length or the digits.
